serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial add/subtract controller that reuses one 1-bit full-adder cell for multi-bit operands. Latches two WIDTH-bit operands on a start pulse and feeds them LSB-first through the cell, one bit per enabled clock. Holds the running carry in a flop and assembles the result in a shift register. Sits between the chip's input pins and the output pins of the adder design, and replaces a ripple chain of full adders.

## Interface

- WIDTH, default 8: operand and result width; legal range 2..16.

- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low; all flops clear on assertion.
- ena  in  1  clock-enable. When 0, every register holds its value.
- start  in  1  request. Sampled only when the FSM is in IDLE or DONE and ena=1.
- sub  in  1  1 = compute op_a − op_b; 0 = compute op_a + op_b + cin.
- cin  in  1  carry-in for add. Ignored when sub=1.
- op_a  in  WIDTH  operand A, sampled with start.
- op_b  in  WIDTH  operand B, sampled with start.
- busy  out  1  1 while the FSM is in SHIFT.
- done  out  1  one-cycle pulse in DONE.
- sum  out  WIDTH  registered result. Holds until the next completion.
- cout  out  1  registered carry-out. For subtract, 1 = no borrow.

## Operation

- FSM states: IDLE, SHIFT, DONE. The reset state is IDLE.
- IDLE with start=1:
  - a_sh <= op_a.
  - b_sh <= sub ? ~op_b : op_b.
  - carry <= sub ? 1 : cin.
  - bit counter <= 0.
  - Next state is SHIFT.
- SHIFT, once per enabled edge:
  - The cell computes s = a_sh[0]^b_sh[0]^carry and c = majority(a_sh[0], b_sh[0], carry).
  - a_sh and b_sh shift right by one.
  - s shifts into the MSB of r_sh (r_sh shifts right).
  - carry <= c.
  - The counter increments.
  - On the edge where the counter equals WIDTH−1: sum <= final r_sh including this bit, cout <= c, next state is DONE.
- DONE:
  - done=1 for exactly one enabled cycle.
  - start=1 here is accepted exactly as in IDLE, giving back-to-back operation.
  - Otherwise the next state is IDLE.
- start while in SHIFT is ignored and not queued.
- sum and cout change only on entry to DONE. Intermediate bits are never visible on sum.
- Arithmetic is modulo 2^WIDTH. cout is bit WIDTH of the true unsigned sum. No signed-overflow flag.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, counter=0, all shift registers 0.
- Reset asserted mid-operation: the operation is discarded and outputs return to their reset values immediately (asynchronous). After release the FSM sits in IDLE.

## Timing

- Start sampled at edge E (ena=1):
  - busy=1 from E through E+WIDTH.
  - Bits 0..WIDTH−1 are processed at edges E+1..E+WIDTH.
  - done=1 and the new sum/cout are valid in the cycle after edge E+WIDTH.
- Latency from start edge to the done cycle: WIDTH+1 edges. Back-to-back throughput: one result per WIDTH+1 enabled cycles.
- ena=0 stretches every phase by the number of disabled cycles. done remains high across disabled cycles until the next enabled edge.
- busy and done are registered decodes of the state. They are never combinational from start.
- The only combinational path is the cell itself, from the shift-register LSBs and carry to the next-state logic.

## Structure

Package serial_add_pkg contains:
- the state enum (IDLE, SHIFT, DONE);
- the default WIDTH constant;
- the counter width, $clog2(WIDTH).

Sub-module full_adder_1b:
- purely combinational;
- ports a, b, ci, s, co;
- instanced once.

The controller contains only the sequencing, shift registers and result registers.

## Test plan

- WIDTH=8, add, op_a=8'h3C, op_b=8'h42, cin=0 → sum=8'h7E, cout=0. done is exactly one cycle, 9 edges after the start edge. busy=1 for 8 cycles.
- Add, op_a=8'hFF, op_b=8'h01, cin=0 → sum=8'h00, cout=1. Then op_a=8'hFF, op_b=8'h00, cin=1 → sum=8'h00, cout=1.
- Subtract:
  - op_a=8'h05, op_b=8'h07 → sum=8'hFE, cout=0.
  - op_a=8'h07, op_b=8'h05 → sum=8'h02, cout=1.
  - cin is toggled randomly during both and has no effect.
- start pulsed during SHIFT with different operands → ignored; the first result is unchanged. Start held in DONE → the second operation begins with no IDLE cycle; the second result appears 9 edges later.
- Hold ena=0 for 3 cycles mid-SHIFT → done arrives 3 cycles later, with the same result as without the stall.
- Assert rst_n=0 at bit 4 of an operation → sum=0, cout=0, busy=0 and done=0 immediately. After release, a fresh start completes normally.

Source files
------------

// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial add/subtract controller:
//   - default operand width and the matching bit-counter width
//   - FSM state codes (legacy-compatible constants) and the state enum
//   - majority helper used by the 1-bit full-adder cell
// -----------------------------------------------------------------------------
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    localparam logic [1:0] IDLE_CODE  = 2'd0;
    localparam logic [1:0] SHIFT_CODE = 2'd1;
    localparam logic [1:0] DONE_CODE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE_CODE,
        ST_SHIFT = SHIFT_CODE,
        ST_DONE  = DONE_CODE
    } state_e;

    // Carry-out of a full adder: true when at least two inputs are set.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder_1b.sv
// -----------------------------------------------------------------------------
// full_adder_1b
// Purely combinational 1-bit full adder, the single arithmetic cell reused
// once per bit by the serial controller.
// Ports:
//   a, b  in   operand bits
//   ci    in   carry in
//   s     out  sum bit
//   co    out  carry out
// -----------------------------------------------------------------------------
module full_adder_1b
    import serial_add_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = maj3(a, b, ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial add/subtract controller. Latches two WIDTH-bit operands on a
// start request and feeds them LSB-first through one shared full-adder cell,
// one bit per enabled clock. Subtraction is a - b = a + ~b + 1.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   ena    in   clock enable; all registers hold while low
//   start  in   request, accepted in IDLE or DONE
//   sub    in   1 = op_a - op_b, 0 = op_a + op_b + cin
//   cin    in   carry-in for add, ignored for subtract
//   op_a   in   operand A
//   op_b   in   operand B
//   busy   out  high while shifting
//   done   out  one enabled-cycle pulse when the result is ready
//   sum    out  registered result, updated only on completion
//   cout   out  registered carry-out (subtract: 1 = no borrow)
// -----------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_r,  state_nxt_s;
    logic [WIDTH-1:0]   a_sh_r,   a_sh_nxt_s;
    logic [WIDTH-1:0]   b_sh_r,   b_sh_nxt_s;
    logic [WIDTH-1:0]   r_sh_r,   r_sh_nxt_s;
    logic               carry_r,  carry_nxt_s;
    logic [CNT_W-1:0]   cnt_r,    cnt_nxt_s;
    logic [WIDTH-1:0]   sum_r,    sum_nxt_s;
    logic               cout_r,   cout_nxt_s;
    logic               busy_r,   busy_nxt_s;
    logic               done_r,   done_nxt_s;

    logic               fa_s_s;
    logic               fa_co_s;
    logic [WIDTH-1:0]   r_sh_shift_s;

    // The one shared arithmetic cell, fed from the operand LSBs and the carry.
    full_adder_1b u_cell (
        .a  (a_sh_r[0]),
        .b  (b_sh_r[0]),
        .ci (carry_r),
        .s  (fa_s_s),
        .co (fa_co_s)
    );

    // Result shift register with this cycle's sum bit entering at the MSB;
    // after WIDTH shifts bit 0 of the result has reached position 0.
    assign r_sh_shift_s = {fa_s_s, r_sh_r[WIDTH-1:1]};

    // Next-state and datapath sequencing; everything holds while ena is low.
    always_comb begin
        state_nxt_s = state_r;
        a_sh_nxt_s  = a_sh_r;
        b_sh_nxt_s  = b_sh_r;
        r_sh_nxt_s  = r_sh_r;
        carry_nxt_s = carry_r;
        cnt_nxt_s   = cnt_r;
        sum_nxt_s   = sum_r;
        cout_nxt_s  = cout_r;
        if (ena) begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // Subtract via two's complement: invert B, carry-in 1.
                        a_sh_nxt_s  = op_a;
                        b_sh_nxt_s  = sub ? ~op_b : op_b;
                        carry_nxt_s = sub ? 1'b1 : cin;
                        cnt_nxt_s   = '0;
                        state_nxt_s = ST_SHIFT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    a_sh_nxt_s  = {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_nxt_s  = {1'b0, b_sh_r[WIDTH-1:1]};
                    r_sh_nxt_s  = r_sh_shift_s;
                    carry_nxt_s = fa_co_s;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        sum_nxt_s   = r_sh_shift_s;
                        cout_nxt_s  = fa_co_s;
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // busy/done are decoded from the next state so they leave as flops.
    always_comb begin
        busy_nxt_s = (state_nxt_s == ST_SHIFT);
        done_nxt_s = (state_nxt_s == ST_DONE);
    end

    // FSM and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Operand/result shift registers, running carry and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            r_sh_r  <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            a_sh_r  <= a_sh_nxt_s;
            b_sh_r  <= b_sh_nxt_s;
            r_sh_r  <= r_sh_nxt_s;
            carry_r <= carry_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Result registers, written only on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            sum_r  <= sum_nxt_s;
            cout_r <= cout_nxt_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       sub;
    logic       cin;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int vectors     = 0;
    int miscompares = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // One rising edge, then back to the falling edge for driving/sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a one-cycle start; returns just after the start edge E.
    task automatic apply_start(input logic s_sub, input logic s_cin,
                               input logic [7:0] a, input logic [7:0] b);
        start = 1'b1;
        sub   = s_sub;
        cin   = s_cin;
        op_a  = a;
        op_b  = b;
        step();
        start = 1'b0;
    endtask

    // Step until done is seen (bounded); edges = edges taken here.
    task automatic wait_done(input bit toggle_cin, output int edges, output bit ok);
        edges = 0;
        ok    = 1'b0;
        while (edges < 40 && !ok) begin
            if (done === 1'b1) begin
                ok = 1'b1;
            end else begin
                if (toggle_cin) cin = 1'($urandom_range(1, 0));
                step();
                edges++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        op_a  = 8'h00;
        op_b  = 8'h00;
        step();
        step();
        vectors++;
        if ({busy, done, cout, sum} !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b done=%b cout=%b sum=%h expected all 0", busy, done, cout, sum);
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if ({busy, done, cout, sum} !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_release_idle: got busy=%b done=%b cout=%b sum=%h expected all 0", busy, done, cout, sum);
        end
    endtask

    task automatic test_add_basic();
        int busy_cycles = 0;
        apply_start(1'b0, 1'b0, 8'h3C, 8'h42);
        for (int k = 0; k < 8; k++) begin
            if (busy === 1'b1) busy_cycles++;
            vectors++;
            if (done !== 1'b0 || sum !== 8'h00) begin
                miscompares++;
                $display("FAIL add_basic_during_shift k=%0d: got done=%b sum=%h expected done=0 sum=00", k, done, sum);
            end
            step();
        end
        vectors++;
        if (busy_cycles != 8) begin
            miscompares++;
            $display("FAIL add_basic_busy_len: got %0d cycles expected 8", busy_cycles);
        end
        vectors++;
        if ({done, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 8'h7E}) begin
            miscompares++;
            $display("FAIL add_basic_result: got done=%b busy=%b cout=%b sum=%h expected done=1 busy=0 cout=0 sum=7e", done, busy, cout, sum);
        end
        step();
        vectors++;
        if (done !== 1'b0 || sum !== 8'h7E) begin
            miscompares++;
            $display("FAIL add_basic_done_pulse: got done=%b sum=%h expected done=0 sum=7e", done, sum);
        end
    endtask

    task automatic test_add_carry();
        int e;
        bit ok;
        apply_start(1'b0, 1'b0, 8'hFF, 8'h01);
        wait_done(1'b0, e, ok);
        vectors++;
        if (!ok || {cout, sum} !== 9'h100) begin
            miscompares++;
            $display("FAIL add_ff_01: got ok=%b cout=%b sum=%h expected cout=1 sum=00", ok, cout, sum);
        end
        step();
        apply_start(1'b0, 1'b1, 8'hFF, 8'h00);
        wait_done(1'b0, e, ok);
        vectors++;
        if (!ok || {cout, sum} !== 9'h100) begin
            miscompares++;
            $display("FAIL add_ff_00_cin: got ok=%b cout=%b sum=%h expected cout=1 sum=00", ok, cout, sum);
        end
        step();
    endtask

    task automatic test_sub();
        int e;
        bit ok;
        apply_start(1'b1, 1'b0, 8'h05, 8'h07);
        wait_done(1'b1, e, ok);
        vectors++;
        if (!ok || {cout, sum} !== 9'h0FE) begin
            miscompares++;
            $display("FAIL sub_05_07: got ok=%b cout=%b sum=%h expected cout=0 sum=fe", ok, cout, sum);
        end
        step();
        apply_start(1'b1, 1'b1, 8'h07, 8'h05);
        wait_done(1'b1, e, ok);
        vectors++;
        if (!ok || {cout, sum} !== 9'h102) begin
            miscompares++;
            $display("FAIL sub_07_05: got ok=%b cout=%b sum=%h expected cout=1 sum=02", ok, cout, sum);
        end
        cin = 1'b0;
        step();
    endtask

    task automatic test_start_during_shift();
        int e;
        bit ok;
        apply_start(1'b0, 1'b0, 8'h3C, 8'h42);
        step();
        step();
        apply_start(1'b1, 1'b1, 8'h11, 8'h99);
        wait_done(1'b0, e, ok);
        vectors++;
        if (!ok || (e + 3) != 8 || {cout, sum} !== 9'h07E) begin
            miscompares++;
            $display("FAIL start_in_shift: got ok=%b edges=%0d cout=%b sum=%h expected edges=8 cout=0 sum=7e", ok, e + 3, cout, sum);
        end
        step();
        step();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_shift_not_queued: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int e;
        bit ok;
        apply_start(1'b0, 1'b0, 8'h10, 8'h20);
        wait_done(1'b0, e, ok);
        vectors++;
        if (!ok || {cout, sum} !== 9'h030) begin
            miscompares++;
            $display("FAIL b2b_first: got ok=%b cout=%b sum=%h expected cout=0 sum=30", ok, cout, sum);
        end
        apply_start(1'b0, 1'b1, 8'h0F, 8'h01);
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h30) begin
            miscompares++;
            $display("FAIL b2b_no_idle: got busy=%b done=%b sum=%h expected busy=1 done=0 sum=30", busy, done, sum);
        end
        wait_done(1'b0, e, ok);
        vectors++;
        if (!ok || (e + 1) != 9 || {cout, sum} !== 9'h011) begin
            miscompares++;
            $display("FAIL b2b_second: got ok=%b edges=%0d cout=%b sum=%h expected edges=9 cout=0 sum=11", ok, e + 1, cout, sum);
        end
        step();
    endtask

    task automatic test_stall();
        int e;
        bit ok;
        apply_start(1'b0, 1'b1, 8'hA5, 8'h5A);
        step();
        step();
        step();
        ena = 1'b0;
        step();
        step();
        step();
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold: got busy=%b done=%b expected 1 0", busy, done);
        end
        ena = 1'b1;
        wait_done(1'b0, e, ok);
        vectors++;
        if (!ok || (e + 6) != 11 || {cout, sum} !== 9'h100) begin
            miscompares++;
            $display("FAIL stall_result: got ok=%b edges=%0d cout=%b sum=%h expected edges=11 cout=1 sum=00", ok, e + 6, cout, sum);
        end
        ena = 1'b0;
        step();
        step();
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_done_held: got done=%b expected 1", done);
        end
        ena = 1'b1;
        step();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_done_clear: got done=%b expected 0", done);
        end
    endtask

    task automatic test_reset_mid_op();
        int e;
        bit ok;
        apply_start(1'b0, 1'b0, 8'h3C, 8'h42);
        wait_done(1'b0, e, ok);
        step();
        apply_start(1'b0, 1'b1, 8'hF0, 8'h0F);
        step();
        step();
        step();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, cout, sum} !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_mid_op: got busy=%b done=%b cout=%b sum=%h expected all 0", busy, done, cout, sum);
        end
        step();
        rst_n = 1'b1;
        step();
        vectors++;
        if ({busy, done, cout, sum} !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_mid_op_idle: got busy=%b done=%b cout=%b sum=%h expected all 0", busy, done, cout, sum);
        end
        apply_start(1'b0, 1'b0, 8'h07, 8'h05);
        wait_done(1'b0, e, ok);
        vectors++;
        if (!ok || (e + 1) != 9 || {cout, sum} !== 9'h00C) begin
            miscompares++;
            $display("FAIL reset_fresh_op: got ok=%b edges=%0d cout=%b sum=%h expected edges=9 cout=0 sum=0c", ok, e + 1, cout, sum);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_add_carry();
        test_sub();
        test_start_during_shift();
        test_back_to_back();
        test_stall();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
